test_result_reader: RTL



---
 rtl/test_result_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/test_result_reader.sv
// Reads the PUF test result bytes back from BRAM once test_done rises and
// streams them, followed by a modulo-256 checksum, over a valid/ready byte port.
module test_result_reader #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned BASE_ADDR  = 1,
    parameter int unsigned N_RESULTS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  test_done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [7:0]            mem_dout,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  read_done
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [7:0]            LAST_IDX = 8'(N_RESULTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PRESENT,
        CSUM,
        DONE
    } state_t;

    state_t     state;
    logic       s1, s2, s3;
    logic [7:0] idx;
    logic [7:0] sum;
    logic       start;
    logic       accept;

    assign start  = s2 & ~s3;
    assign accept = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            idx       <= 8'd0;
            sum       <= 8'd0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            read_done <= 1'b0;
        end else begin
            // test_done crosses from the test FSM's clock domain
            s1 <= test_done;
            s2 <= s1;
            s3 <= s2;

            case (state)
                IDLE: begin
                    idx <= 8'd0;
                    sum <= 8'd0;
                    if (start) begin
                        state     <= REQ;
                        mem_re    <= 1'b1;
                        mem_raddr <= BASE;
                        busy      <= 1'b1;
                    end
                end
                REQ: begin
                    mem_re <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    out_data  <= mem_dout;
                    sum       <= sum + mem_dout;
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            // out_valid stays high straight into the checksum byte
                            out_data <= sum;
                            state    <= CSUM;
                        end else begin
                            idx       <= idx + 8'd1;
                            out_valid <= 1'b0;
                            mem_re    <= 1'b1;
                            mem_raddr <= BASE + ADDR_WIDTH'(idx + 8'd1);
                            state     <= REQ;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        read_done <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Held flag must fall before another readout can arm
                    if (!s2) begin
                        read_done <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_re    <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    read_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
